// File: rtl/vx_ttu_pkg.sv
// Shared types for the TTU responder: master state codes, responder FSM states, helpers.
// Pure declarations, no timing; no flow control of its own.
package vx_ttu_pkg;

    typedef enum logic [2:0] {
        TTU_IDLE    = 3'd0,
        TTU_WAIT    = 3'd1,
        TTU_SWAP    = 3'd2,
        TTU_RUN     = 3'd3,
        TTU_RESTORE = 3'd4
    } ttu_state_e;

    typedef enum logic [2:0] {
        R_IDLE,
        R_DRAIN,
        R_HOLD,
        R_SWAP,
        R_RUN,
        R_WAITRST,
        R_RDRAIN,
        R_RESTORE
    } resp_state_e;

    localparam int ONEHOT_W = 32;

    // Callers truncate to their thread count; tid must stay below ONEHOT_W.
    function automatic logic [ONEHOT_W-1:0] onehot_tid(input logic [4:0] tid);
        onehot_tid = 32'd1 << tid;
    endfunction

    // Unused master codes fold into IDLE so a glitching master aborts rather than hangs.
    function automatic ttu_state_e decode_ttu_state(input logic [2:0] raw);
        if (raw > 3'd4) begin
            return TTU_IDLE;
        end
        return ttu_state_e'(raw);
    endfunction

endpackage

// File: rtl/vx_inflight_counter.sv
// Saturating up/down count of issued-but-uncommitted instructions; is_zero_o is registered.
// Latency: one cycle from issue/commit to is_zero_o; no backpressure, never blocks.
module vx_inflight_counter #(
    parameter int WIDTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic dec_i,
    output logic is_zero_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero_o = (cnt_q == '0);

    // Either of these means issue/commit bookkeeping upstream is broken.
    cnt_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(inc_i && !dec_i && cnt_q == CNT_MAX));
    cnt_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(dec_i && !inc_i && cnt_q == '0));

endmodule

// File: rtl/vx_ttu_responder.sv
// Core-side TTU slave: stalls issue, waits for drain, swaps a warp into the ISR and back.
// Latency: drained >= 2 cycles after WAIT; wctl_* held stable until wctl_ready accepts.
module vx_ttu_responder
    import vx_ttu_pkg::*;
#(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int INFLIGHT_W  = 6,
    localparam int NW_WIDTH   = (NUM_WARPS   > 1) ? $clog2(NUM_WARPS)   : 1,
    localparam int NT_WIDTH   = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       ttu_state,
    input  logic [XLEN-1:0]                  isr_pc,
    input  logic [NW_WIDTH-1:0]              ttu_wid,
    input  logic [NT_WIDTH-1:0]              ttu_tid,
    input  logic [NUM_THREADS-1:0]           interrupted_tmask,
    input  logic [XLEN-1:0]                  interrupted_pc,
    output logic                             pipeline_drained,
    output logic                             thread_found,
    output logic [NUM_THREADS-1:0]           current_thread_mask,
    output logic [XLEN-1:0]                  current_pc,
    output logic                             isr_done,
    output logic                             sched_stall,
    input  logic                             issue_fire,
    input  logic                             commit_fire,
    input  logic [NUM_WARPS*NUM_THREADS-1:0] warp_tmask_in,
    input  logic [NUM_WARPS*XLEN-1:0]        warp_pc_in,
    input  logic [NUM_WARPS-1:0]             warp_barrier_stalled,
    input  logic                             isr_ret_valid,
    input  logic [NW_WIDTH-1:0]              isr_ret_wid,
    output logic                             wctl_valid,
    output logic [NW_WIDTH-1:0]              wctl_wid,
    output logic [XLEN-1:0]                  wctl_pc,
    output logic [NUM_THREADS-1:0]           wctl_tmask,
    input  logic                             wctl_ready
);

    resp_state_e              state_q, state_d;
    ttu_state_e               mst;
    logic                     cnt_zero;
    logic                     wctl_fire;

    logic                     stall_q, stall_d;
    logic                     armed_q, armed_d;
    logic                     drained_q, drained_d;
    logic                     found_q, found_d;
    logic [XLEN-1:0]          cur_pc_q, cur_pc_d;
    logic [NUM_THREADS-1:0]   cur_mask_q, cur_mask_d;
    logic                     done_q, done_d;
    logic                     wvld_q, wvld_d;
    logic [NW_WIDTH-1:0]      wwid_q, wwid_d;
    logic [XLEN-1:0]          wpc_q, wpc_d;
    logic [NUM_THREADS-1:0]   wtmask_q, wtmask_d;

    vx_inflight_counter #(
        .WIDTH (INFLIGHT_W)
    ) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (issue_fire),
        .dec_i     (commit_fire),
        .is_zero_o (cnt_zero)
    );

    assign mst       = decode_ttu_state(ttu_state);
    assign wctl_fire = wvld_q && wctl_ready;

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        armed_d    = armed_q;
        drained_d  = drained_q;
        found_d    = found_q;
        cur_pc_d   = cur_pc_q;
        cur_mask_d = cur_mask_q;
        done_d     = 1'b0;
        wvld_d     = wvld_q;
        wwid_d     = wwid_q;
        wpc_d      = wpc_q;
        wtmask_d   = wtmask_q;

        case (state_q)
            R_IDLE: begin
                if (mst == TTU_WAIT) begin
                    stall_d = 1'b1;
                    armed_d = 1'b0;
                    state_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                // armed_q marks that the stall has been visible to the scheduler for a full cycle.
                armed_d = 1'b1;
                if (armed_q && cnt_zero) begin
                    drained_d  = 1'b1;
                    cur_pc_d   = warp_pc_in[int'(ttu_wid)*XLEN +: XLEN];
                    cur_mask_d = warp_tmask_in[int'(ttu_wid)*NUM_THREADS +: NUM_THREADS];
                    found_d    = ~warp_barrier_stalled[ttu_wid];
                    state_d    = R_HOLD;
                end
            end
            R_HOLD: begin
                if (mst == TTU_SWAP && found_q) begin
                    wvld_d   = 1'b1;
                    wwid_d   = ttu_wid;
                    wpc_d    = isr_pc;
                    wtmask_d = NUM_THREADS'(onehot_tid(5'(ttu_tid)));
                    state_d  = R_SWAP;
                end
            end
            R_SWAP: begin
                if (wctl_fire) begin
                    wvld_d    = 1'b0;
                    stall_d   = 1'b0;
                    drained_d = 1'b0;
                    found_d   = 1'b0;
                    state_d   = R_RUN;
                end
            end
            R_RUN: begin
                if (isr_ret_valid && isr_ret_wid == ttu_wid) begin
                    done_d  = 1'b1;
                    state_d = R_WAITRST;
                end
            end
            R_WAITRST: begin
                if (mst == TTU_RESTORE) begin
                    stall_d = 1'b1;
                    armed_d = 1'b0;
                    state_d = R_RDRAIN;
                end
            end
            R_RDRAIN: begin
                armed_d = 1'b1;
                if (armed_q && cnt_zero) begin
                    wvld_d   = 1'b1;
                    wwid_d   = ttu_wid;
                    wpc_d    = interrupted_pc;
                    wtmask_d = interrupted_tmask;
                    state_d  = R_RESTORE;
                end
            end
            R_RESTORE: begin
                if (wctl_fire) begin
                    wvld_d  = 1'b0;
                    stall_d = 1'b0;
                    state_d = R_IDLE;
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase

        // A pending redirect must complete, so only the non-handshake states honour an abort.
        if (mst == TTU_IDLE && state_q != R_SWAP && state_q != R_RESTORE) begin
            state_d    = R_IDLE;
            stall_d    = 1'b0;
            armed_d    = 1'b0;
            drained_d  = 1'b0;
            found_d    = 1'b0;
            cur_pc_d   = '0;
            cur_mask_d = '0;
            done_d     = 1'b0;
            wvld_d     = 1'b0;
            wwid_d     = '0;
            wpc_d      = '0;
            wtmask_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= R_IDLE;
            stall_q    <= 1'b0;
            armed_q    <= 1'b0;
            drained_q  <= 1'b0;
            found_q    <= 1'b0;
            cur_pc_q   <= '0;
            cur_mask_q <= '0;
            done_q     <= 1'b0;
            wvld_q     <= 1'b0;
            wwid_q     <= '0;
            wpc_q      <= '0;
            wtmask_q   <= '0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            armed_q    <= armed_d;
            drained_q  <= drained_d;
            found_q    <= found_d;
            cur_pc_q   <= cur_pc_d;
            cur_mask_q <= cur_mask_d;
            done_q     <= done_d;
            wvld_q     <= wvld_d;
            wwid_q     <= wwid_d;
            wpc_q      <= wpc_d;
            wtmask_q   <= wtmask_d;
        end
    end

    assign pipeline_drained    = drained_q;
    assign thread_found        = found_q;
    assign current_pc          = cur_pc_q;
    assign current_thread_mask = cur_mask_q;
    assign isr_done            = done_q;
    assign sched_stall         = stall_q;
    assign wctl_valid          = wvld_q;
    assign wctl_wid            = wwid_q;
    assign wctl_pc             = wpc_q;
    assign wctl_tmask          = wtmask_q;

endmodule

// File: tb/tb_vx_ttu_responder.sv
// Scoreboarded random episodes of the TTU swap/return/restore handshake.
// Expected snapshots and redirects are queued by the stimulus and checked by a negedge monitor.
module tb_vx_ttu_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   ttu_state = 3'd0;
    logic [31:0]  isr_pc = '0;
    logic [1:0]   ttu_wid = '0;
    logic [1:0]   ttu_tid = '0;
    logic [3:0]   interrupted_tmask = '0;
    logic [31:0]  interrupted_pc = '0;
    logic         pipeline_drained, thread_found, isr_done, sched_stall;
    logic [3:0]   current_thread_mask;
    logic [31:0]  current_pc;
    logic         issue_fire = 1'b0, commit_fire = 1'b0;
    logic [15:0]  warp_tmask_in = '0;
    logic [127:0] warp_pc_in = '0;
    logic [3:0]   warp_barrier_stalled = '0;
    logic         isr_ret_valid = 1'b0;
    logic [1:0]   isr_ret_wid = '0;
    logic         wctl_valid, wctl_ready = 1'b0;
    logic [1:0]   wctl_wid;
    logic [31:0]  wctl_pc;
    logic [3:0]   wctl_tmask;

    vx_ttu_responder dut (
        .clk                  (clk),
        .reset                (reset),
        .ttu_state            (ttu_state),
        .isr_pc               (isr_pc),
        .ttu_wid              (ttu_wid),
        .ttu_tid              (ttu_tid),
        .interrupted_tmask    (interrupted_tmask),
        .interrupted_pc       (interrupted_pc),
        .pipeline_drained     (pipeline_drained),
        .thread_found         (thread_found),
        .current_thread_mask  (current_thread_mask),
        .current_pc           (current_pc),
        .isr_done             (isr_done),
        .sched_stall          (sched_stall),
        .issue_fire           (issue_fire),
        .commit_fire          (commit_fire),
        .warp_tmask_in        (warp_tmask_in),
        .warp_pc_in           (warp_pc_in),
        .warp_barrier_stalled (warp_barrier_stalled),
        .isr_ret_valid        (isr_ret_valid),
        .isr_ret_wid          (isr_ret_wid),
        .wctl_valid           (wctl_valid),
        .wctl_wid             (wctl_wid),
        .wctl_pc              (wctl_pc),
        .wctl_tmask           (wctl_tmask),
        .wctl_ready           (wctl_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  mask;
        logic        found;
    } snap_t;

    typedef struct {
        logic [1:0]  wid;
        logic [31:0] pc;
        logic [3:0]  tmask;
    } redir_t;

    snap_t  snap_q[$];
    redir_t redir_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     exp_done = 0;
    int     got_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares against queued expectations whenever the DUT presents something.
    snap_t  mon_s;
    redir_t mon_r;
    logic   prev_drained = 1'b0;
    logic   prev_done = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_drained = 1'b0;
            prev_done    = 1'b0;
        end else begin
            if (pipeline_drained && !prev_drained) begin
                chk("drain_expected", snap_q.size() > 0, 1);
                if (snap_q.size() > 0) begin
                    mon_s = snap_q.pop_front();
                    chk("snap_pc", current_pc, mon_s.pc);
                    chk("snap_mask", current_thread_mask, mon_s.mask);
                    chk("snap_found", thread_found, mon_s.found);
                end
            end
            if (wctl_valid) begin
                chk("wctl_expected", redir_q.size() > 0, 1);
                if (redir_q.size() > 0) begin
                    mon_r = redir_q[0];
                    chk("wctl_wid", wctl_wid, mon_r.wid);
                    chk("wctl_pc", wctl_pc, mon_r.pc);
                    chk("wctl_tmask", wctl_tmask, mon_r.tmask);
                    if (wctl_ready) begin
                        void'(redir_q.pop_front());
                    end
                end
            end
            if (isr_done) begin
                got_done++;
                chk("isr_done_single_cycle", prev_done, 0);
            end
            prev_drained = pipeline_drained;
            prev_done    = isr_done;
        end
    end

    // Drain with n instructions in flight, retiring one per cycle; returns edge index of drained.
    task automatic drain_phase(input int n, output int lat);
        lat = -1;
        commit_fire = (n > 0);
        for (int c = 0; c < 40 && lat < 0; c++) begin
            step();
            if (c + 1 == n) commit_fire = 1'b0;
            if (pipeline_drained) lat = c;
        end
        commit_fire = 1'b0;
    endtask

    task automatic handshake(input int d, input string tag);
        int held = 0;
        bit seen = 0;
        wctl_ready = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (wctl_valid) seen = 1;
            else step();
        end
        chk({tag, "_valid_seen"}, seen, 1);
        if (!seen) return;
        for (int c = 0; c < d; c++) begin
            step();
            if (wctl_valid) held++;
        end
        chk({tag, "_valid_held"}, held, d);
        wctl_ready = 1'b1;
        step();
        wctl_ready = 1'b0;
        chk({tag, "_valid_drop"}, wctl_valid, 0);
        chk({tag, "_stall_drop"}, sched_stall, 0);
    endtask

    task automatic episode(input logic [1:0] wid, input logic [1:0] tid, input int n,
                           input bit barrier, input bit abort, input int d1, input int d2,
                           input int m, input int nwrong, input logic [31:0] isr,
                           input logic [31:0] tgt_pc, input logic [3:0] tgt_mask,
                           input logic [31:0] ipc, input logic [3:0] imask, input bit rst_run);
        int lat;
        for (int w = 0; w < 4; w++) begin
            warp_pc_in[w*32 +: 32]  = $urandom;
            warp_tmask_in[w*4 +: 4] = 4'($urandom);
        end
        warp_pc_in[int'(wid)*32 +: 32]  = tgt_pc;
        warp_tmask_in[int'(wid)*4 +: 4] = tgt_mask;
        warp_barrier_stalled      = 4'($urandom);
        warp_barrier_stalled[wid] = barrier;
        isr_pc = isr;

        issue_fire = (n > 0);
        repeat (n) step();
        issue_fire = 1'b0;

        ttu_wid   = wid;
        ttu_tid   = tid;
        ttu_state = 3'd1;
        snap_q.push_back('{tgt_pc, tgt_mask, !barrier});
        drain_phase(n, lat);
        chk("drain_latency", lat, (n > 2) ? n : 2);
        chk("stall_while_held", sched_stall, 1);

        if (barrier || abort) begin
            ttu_state = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
            step();
            chk("abort_release", {sched_stall, pipeline_drained, thread_found}, 0);
            ttu_state = 3'd0;
            return;
        end

        ttu_state = 3'd2;
        redir_q.push_back('{wid, isr, 4'(1 << tid)});
        handshake(d1, "swap");
        ttu_state = 3'd3;

        if (rst_run) begin
            issue_fire = 1'b1;
            repeat (3) step();
            issue_fire = 1'b0;
            reset = 1'b1;
            step();
            chk("rst_run_status", {pipeline_drained, thread_found, current_thread_mask, current_pc,
                                   isr_done, sched_stall, wctl_valid}, 0);
            chk("rst_run_wctl", {wctl_wid, wctl_pc, wctl_tmask}, 0);
            reset = 1'b0;
            ttu_state = 3'd0;
            step();
            ttu_state = 3'd1;
            snap_q.push_back('{tgt_pc, tgt_mask, 1'b1});
            drain_phase(0, lat);
            chk("rst_clears_count", lat, 2);
            ttu_state = 3'd0;
            step();
            return;
        end

        issue_fire = (m > 0);
        repeat (m) step();
        issue_fire = 1'b0;
        for (int j = 0; j < nwrong; j++) begin
            isr_ret_valid = 1'b1;
            isr_ret_wid   = wid - 2'(j + 1);
            step();
            chk("isr_done_other_warp", isr_done, 0);
        end
        isr_ret_valid = 1'b1;
        isr_ret_wid   = wid;
        step();
        isr_ret_valid = 1'b0;
        chk("isr_done_pulse", isr_done, 1);
        exp_done++;
        step();
        chk("isr_done_clear", isr_done, 0);

        interrupted_pc    = ipc;
        interrupted_tmask = imask;
        redir_q.push_back('{wid, ipc, imask});
        ttu_state   = 3'd4;
        commit_fire = (m > 0);
        repeat (m) step();
        commit_fire = 1'b0;
        if (m > 0) chk("restore_stall", sched_stall, 1);
        handshake(d2, "restore");
        ttu_state = 3'd0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_status", {pipeline_drained, thread_found, current_thread_mask, current_pc,
                             isr_done, sched_stall, wctl_valid}, 0);
        chk("reset_wctl", {wctl_wid, wctl_pc, wctl_tmask}, 0);
        step();
        reset = 1'b0;
        step();

        // warp1 drain/swap/return/restore with a slow scheduler and a foreign-warp return
        episode(2'd1, 2'd2, 0, 0, 0, 3, 1, 0, 1, 32'h8000, 32'h100, 4'b1011,
                32'h104, 4'b1011, 0);
        // three instructions still in flight when WAIT arrives
        episode(2'd2, 2'd1, 3, 0, 0, 0, 0, 2, 2, 32'h8000, 32'h200, 4'b0110,
                32'h204, 4'b0110, 0);
        // target warp blocked at a barrier: not found, master backs off
        episode(2'd1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 32'h8000, 32'h300, 4'b1111,
                32'h304, 4'b1111, 0);
        // reset while the ISR is running, with instructions in flight
        episode(2'd1, 2'd3, 0, 0, 0, 1, 0, 0, 0, 32'h8000, 32'h400, 4'b0011,
                32'h404, 4'b0011, 1);

        for (int e = 0; e < 25; e++) begin
            episode(2'($urandom), 2'($urandom), $urandom_range(0, 5),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                    $urandom_range(0, 2), 32'($urandom), 32'($urandom),
                    4'($urandom_range(1, 15)), 32'($urandom), 4'($urandom_range(1, 15)), 0);
        end

        repeat (3) step();
        chk("snap_queue_empty", snap_q.size(), 0);
        chk("redir_queue_empty", redir_q.size(), 0);
        chk("isr_done_count", got_done, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vx_ttu_responder.md
Name: vx_ttu_responder

Overview:
- Core-side responder of the Thread Transfer Unit (TTU) handshake. The interrupt controller is the TTU master; this block is its slave.
- Follows the master's state, stalls warp issue, and counts in-flight instructions to detect a drained pipeline.
- Snapshots the target warp's PC and thread mask, then redirects that warp to the ISR with a single thread.
- Detects ISR return, then restores the interrupted warp context. Sits between the interrupt controller and the warp scheduler.

Parameters:
NUM_WARPS, 4, warps per core; NW_WIDTH = max(1, clog2(NUM_WARPS))
NUM_THREADS, 4, threads per warp; NT_WIDTH = max(1, clog2(NUM_THREADS))
XLEN, 32, PC width
INFLIGHT_W, 6, in-flight instruction counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ttu_state  in  3  master state (encoding in Behaviour)
isr_pc  in  XLEN  ISR entry PC
ttu_wid  in  NW_WIDTH  target warp
ttu_tid  in  NT_WIDTH  target thread
interrupted_tmask  in  NUM_THREADS  mask to restore
interrupted_pc  in  XLEN  PC to restore
pipeline_drained  out  1  level: drain complete
thread_found  out  1  valid only while pipeline_drained=1
current_thread_mask  out  NUM_THREADS  snapshot of target warp mask
current_pc  out  XLEN  snapshot of target warp PC
isr_done  out  1  one-cycle pulse: ISR returned
sched_stall  out  1  freezes issue in all warps
issue_fire  in  1  instruction issued
commit_fire  in  1  instruction committed
warp_tmask_in  in  NUM_WARPS*NUM_THREADS  live thread masks
warp_pc_in  in  NUM_WARPS*XLEN  live warp PCs
warp_barrier_stalled  in  NUM_WARPS  warp blocked at barrier
isr_ret_valid  in  1  ISR-return instruction committed
isr_ret_wid  in  NW_WIDTH  warp of that return
wctl_valid  out  1  warp redirect request
wctl_wid  out  NW_WIDTH  redirect target
wctl_pc  out  XLEN  new PC
wctl_tmask  out  NUM_THREADS  new thread mask
wctl_ready  in  1  scheduler accepts redirect

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Master state encoding: IDLE=0, WAIT=1, SWAP=2, RUN=3, RESTORE=4. Codes 5-7 are treated as IDLE.
- Reset values: all outputs 0; internal FSM in R_IDLE; in-flight counter cnt=0.
- In-flight counter (all states):
  - issue_fire alone: +1. commit_fire alone: -1. Both in the same cycle: no change.
  - Saturates at all-ones (no wrap). Clamps at 0 on commit-with-zero. Both conditions fire sim assertions.
- Internal FSM:
  - R_IDLE:
    - ttu_state=WAIT: sched_stall<=1, go R_DRAIN.
  - R_DRAIN:
    - When cnt==0 and sched_stall has already been 1 for at least one cycle: set pipeline_drained.
    - In that same cycle, register current_pc and current_thread_mask from warp ttu_wid.
    - thread_found <= ~warp_barrier_stalled[ttu_wid].
    - Go R_HOLD.
  - R_HOLD:
    - pipeline_drained stays 1 and the snapshots are held stable.
    - ttu_state=SWAP with thread_found=1: go R_SWAP.
    - ttu_state=IDLE (master abort or not-found): clear sched_stall, drained and found; go R_IDLE.
  - R_SWAP:
    - wctl_valid=1, wctl_wid=ttu_wid, wctl_pc=isr_pc, wctl_tmask=one-hot(ttu_tid).
    - All wctl_* fields stay stable until wctl_ready. Transfer happens in the cycle wctl_valid&&wctl_ready.
    - Next cycle: wctl_valid=0, sched_stall=0, pipeline_drained=0; go R_RUN.
  - R_RUN:
    - isr_ret_valid && isr_ret_wid==ttu_wid: isr_done pulses 1 for one cycle, go R_WAITRST.
    - isr_ret_valid from any other warp is ignored.
  - R_WAITRST:
    - ttu_state=RESTORE: sched_stall<=1, go R_RDRAIN.
  - R_RDRAIN:
    - When cnt==0 after at least one stalled cycle, go R_RESTORE.
  - R_RESTORE:
    - wctl_valid=1 with wctl_wid=ttu_wid, wctl_pc=interrupted_pc, wctl_tmask=interrupted_tmask.
    - Same hold-until-ready rule as R_SWAP.
    - On accept: sched_stall=0, go R_IDLE.
- isr_done is asserted for exactly one cycle per ISR.
- ttu_state=IDLE in any state other than R_SWAP or R_RESTORE aborts: outputs go to reset values, except cnt is kept.
- In R_SWAP and R_RESTORE an accepted-pending wctl_valid is never dropped.
- Latency: pipeline_drained no earlier than 2 cycles after WAIT is first seen, with cnt==0.
- reset asserted mid-operation: all outputs and the FSM return to reset values in the next cycle, including cnt.

Decomposition:
- Package vx_ttu_pkg holds:
  - ttu_state_e, the 3-bit enum shared with the master.
  - The internal responder FSM enum.
  - Helper function onehot_tid.
- One sub-module, vx_inflight_counter: saturating up/down counter with an is_zero output and the assertions.

Test Plan:
- cnt=0 at WAIT, warp1 pc=0x100, tmask=4'b1011 -> pipeline_drained=1 at cycle 2; current_pc=0x100; current_thread_mask=4'b1011; thread_found=1.
- 3 instructions in flight at WAIT, one commit per cycle -> pipeline_drained rises exactly 1 cycle after cnt reaches 0.
- SWAP with isr_pc=0x8000, tid=2, wctl_ready held low 3 cycles -> wctl_valid stable for 4 cycles with tmask=4'b0100; sched_stall drops the cycle after accept.
- RUN: isr_ret_valid wid=0 (target is wid 1), then wid=1 -> isr_done stays 0, then pulses exactly one cycle.
- RESTORE with interrupted_pc=0x104, mask=4'b1011 -> redirect issued after drain; FSM returns to R_IDLE.
- warp_barrier_stalled[1]=1 -> thread_found=0; then master IDLE -> stall released; reset in R_RUN -> all outputs 0 and cnt=0 next cycle.
